// File: rtl/alu_pkg.sv
// alu_pkg: function codes, request type and port count shared by the execute-stage ALU users.
package alu_pkg;
  localparam int NUM_ALU_PORTS = 2;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SHL, ALU_LTS, ALU_LTU, ALU_XOR, ALU_SHR, ALU_OR, ALU_AND
  } alu_funct_e;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_funct_e  funct;
    logic        sw;
  } alu_req_t;
endpackage

// File: rtl/alu_arb_alu.sv
// ALU: single-cycle RV32 integer ALU; sw selects subtract on ADD and arithmetic shift on SHR.
module ALU
  import alu_pkg::*;
(
  input  alu_req_t    req,
  output logic [31:0] val
);
  logic [31:0] w_sum;
  logic signed [31:0] w_sra;
  logic [4:0] w_sh;
  assign w_sh = req.b[4:0];
  // Subtract reuses the adder as a + ~b + 1.
  assign w_sum = req.a + (req.sw ? ~req.b : req.b) + {31'd0, req.sw};
  assign w_sra = $signed(req.a) >>> w_sh;
  always_comb
    case (req.funct)
      ALU_ADD: val = w_sum;
      ALU_SHL: val = req.a << w_sh;
      ALU_LTS: val = {31'd0, $signed(req.a) < $signed(req.b)};
      ALU_LTU: val = {31'd0, req.a < req.b};
      ALU_XOR: val = req.a ^ req.b;
      ALU_SHR: val = req.sw ? w_sra : req.a >> w_sh;
      ALU_OR:  val = req.a | req.b;
      default: val = req.a & req.b;
    endcase
endmodule

// File: rtl/alu_arb.sv
// alu_arb: two-port round-robin arbiter driving one shared ALU through a one-entry response buffer.
// Define ALU_ARB_LOCK_EN to honour req_lock (grant stays on a port across dependent operations).
module alu_arb
  import alu_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic                                clock,
  input  logic                                rstn,
  input  logic [NUM_ALU_PORTS-1:0]            req_valid,
  output logic [NUM_ALU_PORTS-1:0]            req_ready,
  input  logic [NUM_ALU_PORTS-1:0][31:0]      req_a,
  input  logic [NUM_ALU_PORTS-1:0][31:0]      req_b,
  input  logic [NUM_ALU_PORTS-1:0][2:0]       req_funct,
  input  logic [NUM_ALU_PORTS-1:0]            req_sw,
  input  logic [NUM_ALU_PORTS-1:0]            req_lock,
  output logic [NUM_ALU_PORTS-1:0]            resp_valid,
  input  logic [NUM_ALU_PORTS-1:0]            resp_ready,
  output logic [31:0]                         resp_val
);
  logic r_rb_vld, r_rb_id, r_pri;
  logic [31:0] r_rb_val;
  logic w_can_acc, w_acc, w_gnt, w_rr_gnt;
  logic [31:0] w_val;
  alu_req_t w_alu_req;
  // A buffer being drained this cycle can take a new result in the same cycle.
  assign w_can_acc = !r_rb_vld || resp_ready[r_rb_id];
  assign w_rr_gnt = &req_valid ? r_pri : req_valid[1];
`ifdef ALU_ARB_LOCK_EN
  logic r_lk_vld, r_lk_id;
  assign w_gnt = (r_lk_vld && req_valid[r_lk_id]) ? r_lk_id : w_rr_gnt;
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) begin
      r_lk_vld <= 1'b0;
      r_lk_id  <= 1'b0;
    end else if (w_acc) begin
      r_lk_vld <= req_lock[w_gnt];
      r_lk_id  <= w_gnt;
    end else if (!req_valid[r_lk_id])
      r_lk_vld <= 1'b0;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_gnt = w_rr_gnt;
`endif
  assign w_acc = rstn && w_can_acc && |req_valid;
  assign req_ready = {w_acc && w_gnt, w_acc && !w_gnt};
  assign w_alu_req = '{a: req_a[w_gnt], b: req_b[w_gnt],
                       funct: alu_funct_e'(req_funct[w_gnt]), sw: req_sw[w_gnt]};
  ALU u_alu (
    .req(w_alu_req),
    .val(w_val)
  );
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) begin
      r_rb_vld <= 1'b0;
      r_rb_id  <= 1'b0;
      r_rb_val <= '0;
      r_pri    <= RR_INIT;
    end else if (w_acc) begin
      r_rb_vld <= 1'b1;
      r_rb_id  <= w_gnt;
      r_rb_val <= w_val;
      r_pri    <= !w_gnt;
    end else if (w_can_acc)
      r_rb_vld <= 1'b0;
  assign resp_valid = {r_rb_vld && r_rb_id, r_rb_vld && !r_rb_id};
  assign resp_val = r_rb_val;
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed and randomized self-checking bench for alu_arb against a behavioural model.
module tb_alu_arb;
  import alu_pkg::*;
  localparam logic RR_INIT = 1'b0;
  logic clock = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] req_valid = '0, req_sw = '0, req_lock = '0, resp_ready = '0;
  logic [1:0] req_ready, resp_valid;
  logic [1:0][31:0] req_a = '0, req_b = '0;
  logic [1:0][2:0] req_funct = '0;
  logic [31:0] resp_val;
  int n_checks = 0, n_errors = 0;
  logic m_vld = 1'b0, m_id = 1'b0, m_pri = RR_INIT, m_lk = 1'b0, m_lkid = 1'b0, m_g = 1'b0;
  logic [31:0] m_val = '0;

  always #5 clock = ~clock;

  alu_arb #(.RR_INIT(RR_INIT)) dut (
    .clock(clock), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_funct(req_funct), .req_sw(req_sw),
    .req_lock(req_lock), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_val(resp_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic sw);
    logic [4:0] sh;
    logic signed [31:0] sa;
    sh = b[4:0];
    sa = a;
    case (f)
      ALU_ADD: return sw ? a - b : a + b;
      ALU_SHL: return a << sh;
      ALU_LTS: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      ALU_LTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR: return a ^ b;
      ALU_SHR: begin
        if (sw) return sa >>> sh;
        return a >> sh;
      end
      ALU_OR:  return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic sw);
    req_a[p] = a;
    req_b[p] = b;
    req_funct[p] = f;
    req_sw[p] = sw;
    req_valid[p] = 1'b1;
  endtask

  // One clock: check outputs against the model, advance the model, land at posedge+1.
  task automatic cycle();
    logic can, g, acc;
    #1;
    can = !m_vld || resp_ready[m_id];
    g = (req_valid == 2'b11) ? m_pri : req_valid[1];
`ifdef ALU_ARB_LOCK_EN
    if (m_lk && req_valid[m_lkid]) g = m_lkid;
`endif
    acc = can && (req_valid != 2'b00);
    chk("req_ready", 32'(req_ready), acc ? (g ? 32'd2 : 32'd1) : 32'd0);
    chk("resp_valid", 32'(resp_valid), m_vld ? (m_id ? 32'd2 : 32'd1) : 32'd0);
    chk("resp_val", resp_val, m_val);
`ifdef ALU_ARB_LOCK_EN
    if (acc) begin
      m_lk = req_lock[g];
      m_lkid = g;
    end else if (!req_valid[m_lkid]) m_lk = 1'b0;
`endif
    if (acc) begin
      m_val = ref_alu(req_a[g], req_b[g], req_funct[g], req_sw[g]);
      m_id = g;
      m_vld = 1'b1;
      m_pri = !g;
      m_g = g;
    end else if (m_vld && resp_ready[m_id]) m_vld = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_mid();
    #2 rstn = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_val", resp_val, 32'd0);
    m_vld = 1'b0; m_id = 1'b0; m_val = '0; m_pri = RR_INIT; m_lk = 1'b0; m_lkid = 1'b0;
    req_valid = '0;
    @(posedge clock);
    #1;
    chk("rst_hold_valid", 32'(resp_valid), 32'd0);
    @(negedge clock) rstn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    req_valid = 2'b11;
    #2;
    chk("por_req_ready", 32'(req_ready), 32'd0);
    chk("por_resp_valid", 32'(resp_valid), 32'd0);
    chk("por_resp_val", resp_val, 32'd0);
    req_valid = '0;
    @(negedge clock) rstn = 1'b1;
    @(posedge clock);
    #1;
    // single ADD on port 0
    set_req(0, 32'd5, 32'd7, ALU_ADD, 1'b0);
    cycle();
    req_valid = '0;
    chk("add_owner", 32'(resp_valid), 32'd1);
    chk("add_val", resp_val, 32'h0000000C);
    resp_ready = 2'b01;
    cycle();
    // port 1 subtract, signed and unsigned compare, back to back
    resp_ready = 2'b11;
    set_req(1, 32'd5, 32'd7, ALU_ADD, 1'b1);
    cycle();
    chk("sub_val", resp_val, 32'hFFFFFFFE);
    chk("sub_owner", 32'(resp_valid), 32'd2);
    set_req(1, 32'hFFFFFFFF, 32'd1, ALU_LTS, 1'b0);
    cycle();
    chk("lts_val", resp_val, 32'd1);
    set_req(1, 32'hFFFFFFFF, 32'd1, ALU_LTU, 1'b0);
    cycle();
    chk("ltu_val", resp_val, 32'd0);
    req_valid = '0;
    cycle();
    // reset while a result is buffered
    resp_ready = '0;
    set_req(1, 32'h80000000, 32'd4, ALU_SHR, 1'b1);
    cycle();
    chk("sra_val", resp_val, 32'hF8000000);
    req_valid = 2'b11;
    reset_mid();
    // both valid: grants alternate from RR_INIT
    resp_ready = 2'b11;
    set_req(0, 32'h00F0F0F0, 32'h0F0F0F0F, ALU_XOR, 1'b0);
    set_req(1, 32'h00F0F0F0, 32'h0F0F0F0F, ALU_OR, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_owner", 32'(resp_valid), (RR_INIT ^ k[0]) ? 32'd2 : 32'd1);
    end
    req_valid = '0;
    cycle();
    // back-pressure: result held, nothing accepted
    resp_ready = '0;
    set_req(0, 32'h00001234, 32'd16, ALU_SHL, 1'b0);
    cycle();
    set_req(1, 32'd1, 32'd2, ALU_AND, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_val", resp_val, 32'h12340000);
    end
    req_valid = 2'b10;
    resp_ready = 2'b01;
    #1;
    chk("drain_refill_ready", 32'(req_ready), 32'd2);
    cycle();
    chk("drain_refill_owner", 32'(resp_valid), 32'd2);
    resp_ready = 2'b11;
    req_valid = '0;
    cycle();
`ifdef ALU_ARB_LOCK_EN
    set_req(1, 32'd9, 32'd1, ALU_ADD, 1'b0);
    req_valid = 2'b10;
    cycle();
    set_req(0, 32'd3, 32'd4, ALU_ADD, 1'b0);
    req_lock = 2'b01;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("lock_owner", 32'(resp_valid), 32'd1);
    end
    req_valid = 2'b10;
    cycle();
    chk("lock_release", 32'(resp_valid), 32'd2);
    req_lock = '0;
    req_valid = '0;
    cycle();
`endif
    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        req_a[p] = $urandom;
        req_b[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        req_funct[p] = 3'($urandom_range(0, 7));
        req_sw[p] = 1'($urandom_range(0, 1));
      end
      req_valid = 2'($urandom_range(0, 3));
      req_lock = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
